// File: rtl/mdl_bdy_out_frz_pkg.sv
// Shared constants and types for the body-output freeze stage.
package pkg_bdy;

  // Supported moduli for the final conditional subtraction.
  localparam logic [31:0] PRM_Q1 = 32'd8816641;
  localparam logic [31:0] PRM_Q2 = 32'd12410881;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } t_bdy_state;

  // Reserved select codes fall back to the first modulus.
  function automatic logic [31:0] f_sel_q(input logic [1:0] ctl);
    return (ctl == 2'd1) ? PRM_Q2 : PRM_Q1;
  endfunction

endpackage

// File: rtl/mdl_bdy_out_frz_skid2.sv
// Two-entry skid buffer; head entry drives the output directly so the
// downstream side sees only registered data.
module mdl_axis_skid2 #(
  parameter int PRM_W = 65
) (
  input  logic             iSYS_CLK,
  input  logic             iSYS_RST,
  input  logic             i_push,
  input  logic [PRM_W-1:0] i_data,
  output logic             o_space,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PRM_W-1:0] o_data
);

  logic [PRM_W-1:0] r_d0;
  logic [PRM_W-1:0] r_d1;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && (r_cnt != 2'd2);
  assign w_pop   = (r_cnt != 2'd0) && i_ready;
  assign o_space = (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_d0;

  // Entry shuffle: push fills the first free slot, pop shifts d1 into the head.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_d0 <= i_data;
          else               r_d1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_d0 <= i_data;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mdl_bdy_out_frz.sv
// Final freeze of butterfly output coefficients: conditional subtract of q
// per lane, framed by a small sequencer, with a skid buffer toward the DMA.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for START; q latched and flags cleared on exit
//   ST_RUN   | accepting input beats while the skid buffer has room
//   ST_DRAIN | all input taken; waiting for the Tlast beat to leave
//   ST_DONE  | one-cycle done pulse, then back to idle
module mdl_bdy_out_frz
  import pkg_bdy::*;
#(
  parameter int PRM_DAXI   = 64,
  parameter int PRM_COEFFS = 16
) (
  input  logic                iSYS_CLK,
  input  logic                iSYS_RST,
  input  logic                iFSM_START,
  input  logic [1:0]          iCTL_Q,
  input  logic                iRs_Tvalid,
  output logic                oRs_Tready,
  input  logic [PRM_DAXI-1:0] iRs_Tdata,
  input  logic                iRs_Tlast,
  output logic                oWm_Tvalid,
  input  logic                iWm_Tready,
  output logic [PRM_DAXI-1:0] oWm_Tdata,
  output logic                oWm_Tlast,
  output logic                oFSM_DONE,
  output logic                oERR_RANGE,
  output logic                oERR_LAST
);

  localparam int LW    = PRM_DAXI / 2;
  localparam int BEATS = PRM_COEFFS / 2;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Two spare bits so both q and 2q compare without truncation.
  localparam int XW    = ((LW > 32) ? LW : 32) + 2;
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  t_bdy_state          r_state;
  t_bdy_state          w_next;
  logic [31:0]         r_q;
  logic [CW-1:0]       r_cnt;
  logic                r_err_range;
  logic                r_err_last;

  logic                w_acc;
  logic                w_final;
  logic [PRM_DAXI-1:0] w_frz;
  logic [1:0]          w_ovr;
  logic                w_skid_space;
  logic [PRM_DAXI:0]   w_skid_out;

  assign w_acc   = iRs_Tvalid && oRs_Tready;
  assign w_final = (r_cnt == LAST_IDX);

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [LW-1:0] w_x;
    logic [XW-1:0] w_xe;
    logic [XW-1:0] w_qe;
    assign w_x  = iRs_Tdata[g*LW +: LW];
    assign w_xe = XW'(w_x);
    assign w_qe = XW'(r_q);
    assign w_frz[g*LW +: LW] = (w_xe >= w_qe) ? LW'(w_xe - w_qe) : w_x;
    assign w_ovr[g] = (w_xe >= (w_qe << 1));
  end

  mdl_axis_skid2 #(
    .PRM_W (PRM_DAXI + 1)
  ) u_skid (
    .iSYS_CLK (iSYS_CLK),
    .iSYS_RST (iSYS_RST),
    .i_push   (w_acc),
    .i_data   ({w_final, w_frz}),
    .o_space  (w_skid_space),
    .o_valid  (oWm_Tvalid),
    .i_ready  (iWm_Tready),
    .o_data   (w_skid_out)
  );

  assign {oWm_Tlast, oWm_Tdata} = w_skid_out;

  // State register.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (iFSM_START) w_next = ST_RUN;
      ST_RUN:   if (w_acc && w_final) w_next = ST_DRAIN;
      ST_DRAIN: if (oWm_Tvalid && iWm_Tready && oWm_Tlast) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on the input stream.
  always_comb begin
    oRs_Tready = 1'b0;
    oFSM_DONE  = 1'b0;
    case (r_state)
      ST_RUN:  oRs_Tready = w_skid_space;
      ST_DONE: oFSM_DONE  = 1'b1;
      default: ;
    endcase
  end

  // Frame bookkeeping: q latch, beat counter and sticky error flags.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      r_q         <= '0;
      r_cnt       <= '0;
      r_err_range <= 1'b0;
      r_err_last  <= 1'b0;
    end else if ((r_state == ST_IDLE) && iFSM_START) begin
      r_q         <= f_sel_q(iCTL_Q);
      r_cnt       <= '0;
      r_err_range <= 1'b0;
      r_err_last  <= 1'b0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + CW'(1);
      if (|w_ovr) r_err_range <= 1'b1;
      if (iRs_Tlast != w_final) r_err_last <= 1'b1;
    end
  end

  assign oERR_RANGE = r_err_range;
  assign oERR_LAST  = r_err_last;

endmodule

// File: tb/tb_mdl_bdy_out_frz.sv
// Directed bench for the body-output freeze stage.
module tb_mdl_bdy_out_frz;

  localparam int unsigned Q1 = 8816641;
  localparam int unsigned Q2 = 12410881;

  logic        clk;
  logic        iSYS_RST;
  logic        iFSM_START;
  logic [1:0]  iCTL_Q;
  logic        iRs_Tvalid;
  logic        oRs_Tready;
  logic [63:0] iRs_Tdata;
  logic        iRs_Tlast;
  logic        oWm_Tvalid;
  logic        iWm_Tready;
  logic [63:0] oWm_Tdata;
  logic        oWm_Tlast;
  logic        oFSM_DONE;
  logic        oERR_RANGE;
  logic        oERR_LAST;

  mdl_bdy_out_frz #(.PRM_DAXI(64), .PRM_COEFFS(16)) dut (
    .iSYS_CLK   (clk),
    .iSYS_RST   (iSYS_RST),
    .iFSM_START (iFSM_START),
    .iCTL_Q     (iCTL_Q),
    .iRs_Tvalid (iRs_Tvalid),
    .oRs_Tready (oRs_Tready),
    .iRs_Tdata  (iRs_Tdata),
    .iRs_Tlast  (iRs_Tlast),
    .oWm_Tvalid (oWm_Tvalid),
    .iWm_Tready (iWm_Tready),
    .oWm_Tdata  (oWm_Tdata),
    .oWm_Tlast  (oWm_Tlast),
    .oFSM_DONE  (oFSM_DONE),
    .oERR_RANGE (oERR_RANGE),
    .oERR_LAST  (oERR_LAST)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [63:0] q_data[$];
  bit          q_last[$];
  int          q_cyc[$];
  int          acc_cyc[$];
  int          done_cnt = 0;
  int          stab_bad = 0;
  bit          p_stall = 0;
  logic [63:0] p_data = '0;
  logic        p_last = 1'b0;

  logic [63:0] fd[8];
  bit          fl[8];
  logic [63:0] ex[8];

  bit tog_en = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int ph = 0;

  always @(posedge clk) cyc++;

  // Observe both stream interfaces mid-cycle, where handshakes are settled.
  always @(negedge clk) begin
    if (oWm_Tvalid && iWm_Tready) begin
      q_data.push_back(oWm_Tdata);
      q_last.push_back(oWm_Tlast);
      q_cyc.push_back(cyc);
    end
    if (iRs_Tvalid && oRs_Tready) acc_cyc.push_back(cyc);
    if (oFSM_DONE) done_cnt++;
    if (p_stall && (!oWm_Tvalid || oWm_Tdata !== p_data || oWm_Tlast !== p_last)) stab_bad++;
    p_stall = oWm_Tvalid && !iWm_Tready;
    p_data  = oWm_Tdata;
    p_last  = oWm_Tlast;
  end

  // Downstream ready: always 1, or the 1,0,0,1 pattern when enabled.
  initial begin
    iWm_Tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) begin
        iWm_Tready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        iWm_Tready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    iFSM_START = 1'b1;
    tick();
    iFSM_START = 1'b0;
  endtask

  task automatic send_beats(input int n);
    for (int b = 0; b < n; b++) begin
      int w = 0;
      bit got = 0;
      iRs_Tvalid = 1'b1;
      iRs_Tdata  = fd[b];
      iRs_Tlast  = fl[b];
      while (!got && w < 200) begin
        @(negedge clk);
        if (oRs_Tready) got = 1;
        else w++;
      end
      if (!got) begin
        chk("send_timeout", got, 1);
        break;
      end
      tick();
    end
    iRs_Tvalid = 1'b0;
    iRs_Tlast  = 1'b0;
  endtask

  task automatic wait_done(output int rdy_hi);
    int w = 0;
    bit seen = 0;
    rdy_hi = 0;
    while (!seen && w < 300) begin
      @(negedge clk);
      if (oRs_Tready) rdy_hi++;
      if (oFSM_DONE) seen = 1;
      else w++;
    end
    chk("done_timeout", seen, 1);
    tick();
  endtask

  task automatic check_frame(input string tag, input int qb);
    chk({tag, "_count"}, q_data.size() - qb, 8);
    for (int k = 0; k < 8; k++) begin
      if (qb + k < q_data.size()) begin
        chk($sformatf("%s_data%0d", tag, k), q_data[qb+k], ex[k]);
        chk($sformatf("%s_last%0d", tag, k), q_last[qb+k], (k == 7));
      end
    end
  endtask

  task automatic load_f1();
    for (int b = 0; b < 8; b++) begin
      fd[b] = (b % 2 == 0) ? {32'(Q1 - 1), 32'd0} : {32'(2 * Q1 - 1), 32'(Q1)};
      fl[b] = (b == 7);
      ex[b] = {32'(Q1 - 1), 32'd0};
    end
  endtask

  task automatic load_q2();
    for (int b = 0; b < 8; b++) begin
      fd[b] = {32'd12410882, 32'd12410882};
      fl[b] = (b == 7);
      ex[b] = {32'd1, 32'd1};
    end
  endtask

  initial begin
    int qb, ab, d0, sb, r, bad, burst, gaps;
    iSYS_RST = 1'b1; iFSM_START = 1'b0; iCTL_Q = 2'd0;
    iRs_Tvalid = 1'b0; iRs_Tdata = '0; iRs_Tlast = 1'b0;
    tick(); tick();
    chk("rst_rs_ready", oRs_Tready, 0);
    chk("rst_wm_valid", oWm_Tvalid, 0);
    chk("rst_wm_data", oWm_Tdata, 0);
    chk("rst_wm_last", oWm_Tlast, 0);
    chk("rst_done", oFSM_DONE, 0);
    chk("rst_err_range", oERR_RANGE, 0);
    chk("rst_err_last", oERR_LAST, 0);
    iSYS_RST = 1'b0;
    tick();
    chk("idle_ready", oRs_Tready, 0);

    // Frame 1: q1 boundary values.
    load_f1();
    iCTL_Q = 2'd0;
    d0 = done_cnt; qb = q_data.size();
    start_pulse();
    send_beats(8);
    wait_done(r);
    chk("f1_ready_drain", r, 0);
    tick(); tick();
    chk("f1_done_once", done_cnt - d0, 1);
    check_frame("f1", qb);
    chk("f1_err_range", oERR_RANGE, 0);
    chk("f1_err_last", oERR_LAST, 0);

    // Frame 2: q2, latency 1, full-rate burst; iCTL_Q change mid-frame ignored.
    load_q2();
    iCTL_Q = 2'd1;
    qb = q_data.size(); ab = acc_cyc.size();
    start_pulse();
    iCTL_Q = 2'd0;
    send_beats(8);
    wait_done(r);
    check_frame("f2", qb);
    if (q_data.size() >= qb + 8 && acc_cyc.size() >= ab + 8) begin
      chk("f2_lat_first", q_cyc[qb] - acc_cyc[ab], 1);
      chk("f2_lat_last", q_cyc[qb+7] - acc_cyc[ab+7], 1);
      chk("f2_burst", q_cyc[qb+7] - q_cyc[qb], 7);
    end

    // Frame 3: downstream back-pressure.
    for (int b = 0; b < 8; b++) begin
      fd[b] = {32'(b + 16), 32'(b)};
      fl[b] = (b == 7);
      ex[b] = fd[b];
    end
    iCTL_Q = 2'd0;
    tog_en = 1; sb = stab_bad; qb = q_data.size();
    start_pulse();
    send_beats(8);
    wait_done(r);
    tog_en = 0;
    check_frame("f3", qb);
    chk("f3_stable", stab_bad - sb, 0);
    burst = 0; gaps = 0;
    for (int k = qb; k + 1 < q_data.size(); k++) begin
      if (q_cyc[k+1] == q_cyc[k] + 1) burst++;
      else gaps++;
    end
    chk("f3_has_burst", burst > 0, 1);
    chk("f3_has_stall", gaps > 0, 1);

    // Frame 4: early Tlast on beat 3 and a 2q lane value.
    for (int b = 0; b < 8; b++) begin
      fd[b] = {32'(2 * b + 1), 32'(2 * b)};
      fl[b] = (b == 3) || (b == 7);
      ex[b] = fd[b];
    end
    fd[5] = {32'd11, 32'(2 * Q1)};
    ex[5] = {32'd11, 32'(Q1)};
    qb = q_data.size();
    start_pulse();
    send_beats(8);
    wait_done(r);
    check_frame("f4", qb);
    chk("f4_err_last", oERR_LAST, 1);
    chk("f4_err_range", oERR_RANGE, 1);

    // Frame 5: reset after 4 beats, then silence, then a clean frame.
    fd[0] = {32'd5, 32'(2 * Q2)}; fl[0] = 0;
    fd[1] = {32'd7, 32'd9};       fl[1] = 1;
    fd[2] = {32'd3, 32'd4};       fl[2] = 0;
    fd[3] = {32'd1, 32'd2};       fl[3] = 0;
    iCTL_Q = 2'd1;
    start_pulse();
    send_beats(4);
    chk("f5_pre_err_range", oERR_RANGE, 1);
    chk("f5_pre_err_last", oERR_LAST, 1);
    iSYS_RST = 1'b1;
    tick();
    iSYS_RST = 1'b0;
    chk("f5_rs_ready", oRs_Tready, 0);
    chk("f5_wm_valid", oWm_Tvalid, 0);
    chk("f5_wm_data", oWm_Tdata, 0);
    chk("f5_wm_last", oWm_Tlast, 0);
    chk("f5_done", oFSM_DONE, 0);
    chk("f5_err_range", oERR_RANGE, 0);
    chk("f5_err_last", oERR_LAST, 0);
    qb = q_data.size(); bad = 0;
    iRs_Tvalid = 1'b1; iRs_Tdata = 64'h1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (oWm_Tvalid || oRs_Tready) bad++;
    end
    tick();
    iRs_Tvalid = 1'b0;
    chk("f5_quiet", bad, 0);
    chk("f5_no_output", q_data.size() - qb, 0);
    load_f1();
    iCTL_Q = 2'd0;
    qb = q_data.size();
    start_pulse();
    send_beats(8);
    wait_done(r);
    check_frame("f5b", qb);
    chk("f5b_err_range", oERR_RANGE, 0);

    // Frame 6: START held high gives back-to-back frames.
    load_f1();
    iCTL_Q = 2'd0;
    d0 = done_cnt; qb = q_data.size();
    iFSM_START = 1'b1;
    tick();
    send_beats(8);
    wait_done(r);
    chk("f6a_ready_drain", r, 0);
    check_frame("f6a", qb);
    load_q2();
    iCTL_Q = 2'd1;
    qb = q_data.size();
    tick();
    iFSM_START = 1'b0;
    send_beats(8);
    wait_done(r);
    chk("f6b_ready_drain", r, 0);
    check_frame("f6b", qb);
    tick(); tick();
    chk("f6_done_count", done_cnt - d0, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
